kbd_event_buffer: RTL and testbench
===================================

// Module: kbd_event_buffer
// PURPOSE
//  Buffers keyboard characters between ps2_drv (producer) and the CPU system (consumer).
//  Decouples PS/2 arrival rate from a CPU clock that may run slow or in single-step mode.
//  Sits on the kbd_int_req / kbd_int_ack / kbd_ascii path, between ps2_drv and system.
//  Exposes a level interrupt while non-empty, and a sticky overflow flag.
// PARAMETERS
//  DATA_W      8   character width
//  DEPTH_LOG2  3   log2 of FIFO depth (default depth 8)
// PORTS
//  clk50M       in   1            system clock; all logic on posedge
//  rst          in   1            reset, synchronous, active-high
//  up_req       in   1            ps2_drv int_req (level; data valid while high)
//  up_data      in   DATA_W       ps2_drv kbd_ascii
//  up_ack       out  1            to ps2_drv int_ack (four-phase)
//  dn_int       out  1            to system kbd_int; high while FIFO non-empty
//  dn_data      out  DATA_W       head entry; valid while dn_int=1
//  dn_ack       in   1            from system kbd_int_ack; clk_cpu domain, asynchronous here
//  clr_ovf      in   1            one-cycle pulse; clears ovf
//  ovf          out  1            sticky: a character was dropped because the FIFO was full
//  count        out  DEPTH_LOG2+1 occupancy, 0..2**DEPTH_LOG2
// BEHAVIOUR
//  Reset values: up_ack=0, dn_int=0, dn_data=0, ovf=0, count=0.
//  Reset clears the pointers and the handshake FSM, also mid-transfer. Memory contents need no reset.
//  Upstream FSM (four-phase):
//   - IDLE: if up_req=1, sample up_data and go to ACK; set up_ack=1 on the next cycle.
//   - ACK: hold up_ack=1 until up_req=0, then up_ack=0 and return to IDLE.
//   - Exactly one push attempt per req high-phase. A req that stays high never pushes twice.
//  Push in the IDLE->ACK cycle: write if not full. If full, drop the char and set ovf=1.
//   - Upstream is acked even when the char is dropped, so ps2_drv never stalls.
//  Downstream: dn_ack passes through a 2-flop synchroniser, then a rising-edge detector.
//   - Each rising edge pops one entry. A pop on an empty FIFO is ignored; count stays 0.
//   - A long ack level pops only once.
//   - The synchroniser adds 2-3 clk50M of latency from dn_ack rise to the pop.
//  dn_data = mem[rd_ptr], registered. It updates the cycle after a pop.
//  dn_int = (count != 0), registered. It rises 1 cycle after the first push.
//  Pointers are DEPTH_LOG2 bits and wrap modulo depth. Full when count == 2**DEPTH_LOG2.
//  Simultaneous push and pop:
//   - Both occur and count is unchanged.
//   - When full, the pop frees a slot first, so the push succeeds and ovf is not set.
//   - When empty, the push lands and the pop is ignored; a pop is valid only if count != 0 before the cycle.
//  ovf: set by a drop; cleared by clr_ovf. If both happen in the same cycle, set wins.
// STRUCTURE
//  Shared header armcpu_defs.vh: KBD_DATA_W and KBD_FIFO_DEPTH_LOG2 defaults.
//   - The same header holds the FSM state encodings KBD_ST_IDLE=1'b0 and KBD_ST_ACK=1'b1.
//  Sub-module sync_fifo (DATA_W, DEPTH_LOG2): storage, pointers, count, full/empty.
//   - Inputs push and pop; outputs head and count. Reusable for the UART rx path.
//  This module contains the upstream FSM, the dn_ack synchroniser and edge detector, and ovf.
// TESTING
//  1. Reset, then up_req high with 0x41, dropped after ack -> up_ack=1 two cycles after req.
//     Then dn_int=1, dn_data=0x41, count=1; a dn_ack pulse gives count=0 and dn_int=0.
//  2. Push 0x30..0x37 (8 chars) with no dn_ack -> count=8, ovf=0. A 9th char 0x38 is acked.
//     Result: ovf=1 and count=8; popping returns 0x30..0x37 in order.
//  3. Hold up_req high for 50 cycles with 0x55 -> exactly one push (count=1); up_ack stays high until req falls.
//  4. FIFO full (8 entries); a push and a synchronised dn_ack edge land in the same cycle.
//     Result: count stays 8, ovf=0, and the new char is the last entry popped.
//  5. dn_ack held high for 100 cycles with 3 entries -> exactly one pop (count=2). dn_ack on an empty FIFO leaves count=0.
//  6. Assert rst while up_ack=1 and count=5 -> next cycle up_ack=0, count=0, dn_int=0, ovf=0.
//     A new req after reset is accepted normally.

Source files
------------

// File: rtl/kbd_event_buffer_pkg.sv
// ============================================================================
//  Module      : kbd_event_buffer_pkg
//  Description : Shared defaults for the keyboard event buffer: character
//                width, FIFO depth and the upstream handshake state codes.
//  Contents    : KBD_DATA_W, KBD_FIFO_DEPTH_LOG2, KBD_ST_IDLE, KBD_ST_ACK
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kbd_event_buffer_pkg;
   localparam int KBD_DATA_W          = 8;
   localparam int KBD_FIFO_DEPTH_LOG2 = 3;

   // Upstream four-phase handshake states
   localparam logic [0:0] KBD_ST_IDLE = 1'b0;
   localparam logic [0:0] KBD_ST_ACK  = 1'b1;
endpackage

`default_nettype wire

// File: rtl/kbd_event_buffer_sync_fifo.sv
// ============================================================================
//  Module      : kbd_event_buffer_sync_fifo
//  Description : Single-clock FIFO with registered head output. Push is
//                accepted when not full, or when full together with a valid
//                pop. Pop on empty is ignored. Reusable for other rx paths.
//  Ports       : clk50M, rst          clock / sync active-high reset
//                push_i, wdata_i      write request and data
//                pop_i                read request
//                head_o               registered head entry (0 when empty)
//                count_o              occupancy 0..2**DEPTH_LOG2
//                full_o, empty_o      status, combinational from count
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_event_buffer_sync_fifo
   import kbd_event_buffer_pkg::*;
#(
   parameter int DATA_W     = KBD_DATA_W,
   parameter int DEPTH_LOG2 = KBD_FIFO_DEPTH_LOG2
) (
   input  logic                  clk50M,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic                  pop_i,
   output logic [DATA_W-1:0]     head_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int                DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic [DEPTH_LOG2:0]   count_d;
   logic [DATA_W-1:0]     head_q;
   logic                  wr_en;
   logic                  rd_en;

   assign full_o  = (count_q == DEPTH_CNT);
   assign empty_o = (count_q == '0);

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a
   // push that coincides with a valid pop.
   assign rd_en = pop_i && !empty_o;
   assign wr_en = push_i && (!full_o || rd_en);

   always_comb begin
      count_d = count_q;
      if (wr_en && !rd_en) begin
         count_d = count_q + 1'b1;
      end else if (rd_en && !wr_en) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage needs no reset
   always_ff @(posedge clk50M) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk50M) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         // Forced to 0 when empty so uninitialised storage never shows
         head_q  <= (count_q != '0) ? mem_q[rd_ptr_q] : '0;
      end
   end

   assign head_o  = head_q;
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/kbd_event_buffer.sv
// ============================================================================
//  Module      : kbd_event_buffer
//  Description : Character buffer between ps2_drv and the CPU system.
//                Four-phase upstream handshake, synchronised edge-triggered
//                downstream ack, level interrupt while non-empty, sticky
//                overflow flag.
//  Ports       : clk50M, rst          clock / sync active-high reset
//                up_req, up_data      ps2_drv request level and character
//                up_ack               four-phase ack to ps2_drv
//                dn_int, dn_data      interrupt level and head character
//                dn_ack               async ack from CPU domain (pops on rise)
//                clr_ovf, ovf         overflow clear pulse / sticky flag
//                count                FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_event_buffer
   import kbd_event_buffer_pkg::*;
#(
   parameter int DATA_W     = KBD_DATA_W,
   parameter int DEPTH_LOG2 = KBD_FIFO_DEPTH_LOG2
) (
   input  logic                clk50M,
   input  logic                rst,
   input  logic                up_req,
   input  logic [DATA_W-1:0]   up_data,
   output logic                up_ack,
   output logic                dn_int,
   output logic [DATA_W-1:0]   dn_data,
   input  logic                dn_ack,
   input  logic                clr_ovf,
   output logic                ovf,
   output logic [DEPTH_LOG2:0] count
);

   logic [0:0] state_q;
   logic [0:0] state_d;
   logic       up_ack_q;
   logic       up_ack_d;
   logic       push;
   logic [2:0] ack_sync_q;
   logic       ack_rise;
   logic       pop_ok;
   logic       drop;
   logic       dn_int_q;
   logic       ovf_q;
   logic       fifo_full;
   logic       fifo_empty;
   logic [DEPTH_LOG2:0] fifo_count;

   // ---------------- upstream handshake FSM ----------------
   always_ff @(posedge clk50M) begin
      if (rst) begin
         state_q  <= KBD_ST_IDLE;
         up_ack_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         up_ack_q <= up_ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         KBD_ST_IDLE: if (up_req)  state_d = KBD_ST_ACK;
         KBD_ST_ACK:  if (!up_req) state_d = KBD_ST_IDLE;
      endcase
   end

   // Push only on the IDLE->ACK transition, so a held req pushes once.
   // Ack drops on the same edge the FSM sees req low.
   always_comb begin
      push     = (state_q == KBD_ST_IDLE) && up_req;
      up_ack_d = (state_q == KBD_ST_ACK) && up_req;
   end

   // ---------------- downstream ack synchroniser ----------------
   // [0],[1] form the 2-flop synchroniser, [2] holds the previous value
   always_ff @(posedge clk50M) begin
      if (rst) begin
         ack_sync_q <= '0;
      end else begin
         ack_sync_q <= {ack_sync_q[1:0], dn_ack};
      end
   end

   assign ack_rise = ack_sync_q[1] && !ack_sync_q[2];
   assign pop_ok   = ack_rise && !fifo_empty;
   assign drop     = push && fifo_full && !pop_ok;

   kbd_event_buffer_sync_fifo #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk50M  (clk50M),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (up_data),
      .pop_i   (pop_ok),
      .head_o  (dn_data),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ---------------- interrupt and overflow ----------------
   always_ff @(posedge clk50M) begin
      if (rst) begin
         dn_int_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         dn_int_q <= (fifo_count != '0);
         if (drop) begin
            ovf_q <= 1'b1;          // set beats a simultaneous clear
         end else if (clr_ovf) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign up_ack = up_ack_q;
   assign dn_int = dn_int_q;
   assign ovf    = ovf_q;
   assign count  = fifo_count;

endmodule

`default_nettype wire

// File: tb/tb_kbd_event_buffer.sv
// ============================================================================
//  Module      : tb_kbd_event_buffer
//  Description : Self-checking bench for kbd_event_buffer. Scenario tasks
//                with a queue-based reference model of buffer contents and
//                the overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_kbd_event_buffer;

   logic       clk50M  = 1'b0;
   logic       rst     = 1'b1;
   logic       up_req  = 1'b0;
   logic [7:0] up_data = 8'h00;
   logic       dn_ack  = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       up_ack;
   logic       dn_int;
   logic [7:0] dn_data;
   logic       ovf;
   logic [3:0] count;

   int         total = 0;
   int         bad   = 0;

   // Reference model: buffered characters in arrival order, sticky overflow
   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;

   always #10 clk50M = ~clk50M;

   kbd_event_buffer #(
      .DATA_W     (8),
      .DEPTH_LOG2 (3)
   ) dut (
      .clk50M  (clk50M),
      .rst     (rst),
      .up_req  (up_req),
      .up_data (up_data),
      .up_ack  (up_ack),
      .dn_int  (dn_int),
      .dn_data (dn_data),
      .dn_ack  (dn_ack),
      .clr_ovf (clr_ovf),
      .ovf     (ovf),
      .count   (count)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk50M);
   endtask

   // Full four-phase transfer of one character; updates the model
   task automatic push_char(input logic [7:0] d);
      int i;
      up_data = d;
      up_req  = 1'b1;
      i = 0;
      while (up_ack !== 1'b1 && i < 20) begin
         @(negedge clk50M);
         i++;
      end
      total++;
      if (up_ack !== 1'b1) begin
         bad++;
         $display("FAIL push_ack_rise got=%b want=1", up_ack);
      end
      if (mq.size() == 8) m_ovf = 1'b1;
      else                mq.push_back(d);
      up_req = 1'b0;
      i = 0;
      while (up_ack !== 1'b0 && i < 20) begin
         @(negedge clk50M);
         i++;
      end
      total++;
      if (up_ack !== 1'b0) begin
         bad++;
         $display("FAIL push_ack_fall got=%b want=0", up_ack);
      end
      cyc(2);
   endtask

   task automatic pop_pulse(input int hi);
      dn_ack = 1'b1;
      cyc(hi);
      dn_ack = 1'b0;
      cyc(6);
      if (mq.size() > 0) void'(mq.pop_front());
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cyc(3);
      total++;
      if ({up_ack, dn_int, ovf, count, dn_data} !== 15'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", {up_ack, dn_int, ovf, count, dn_data});
      end
      rst = 1'b0;
      cyc(2);
      total++;
      if (count !== 4'd0 || dn_int !== 1'b0) begin
         bad++;
         $display("FAIL post_reset got count=%0d int=%b want 0/0", count, dn_int);
      end
   endtask

   task automatic test_single;
      up_data = 8'h41;
      up_req  = 1'b1;
      cyc(1);
      total++;
      if (up_ack !== 1'b0) begin
         bad++;
         $display("FAIL single_ack_early got=%b want=0", up_ack);
      end
      total++;
      if (count !== 4'd1) begin
         bad++;
         $display("FAIL single_count_push got=%0d want=1", count);
      end
      cyc(1);
      total++;
      if (up_ack !== 1'b1 || dn_int !== 1'b1 || dn_data !== 8'h41) begin
         bad++;
         $display("FAIL single_after2 got ack=%b int=%b data=%h want 1/1/41", up_ack, dn_int, dn_data);
      end
      up_req = 1'b0;
      cyc(2);
      total++;
      if (up_ack !== 1'b0) begin
         bad++;
         $display("FAIL single_ack_fall got=%b want=0", up_ack);
      end
      dn_ack = 1'b1;
      cyc(2);
      dn_ack = 1'b0;
      cyc(6);
      total++;
      if (count !== 4'd0 || dn_int !== 1'b0) begin
         bad++;
         $display("FAIL single_pop got count=%0d int=%b want 0/0", count, dn_int);
      end
   endtask

   task automatic test_overflow;
      for (int k = 0; k < 8; k++) push_char(8'h30 + 8'(k));
      total++;
      if (count !== 4'd8 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL ovf_fill got count=%0d ovf=%b want 8/0", count, ovf);
      end
      push_char(8'h38);
      total++;
      if (count !== 4'd8 || ovf !== 1'b1) begin
         bad++;
         $display("FAIL ovf_drop got count=%0d ovf=%b want 8/1", count, ovf);
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (dn_data !== 8'h30 + 8'(k)) begin
            bad++;
            $display("FAIL ovf_order[%0d] got=%h want=%h", k, dn_data, 8'h30 + 8'(k));
         end
         pop_pulse(2);
      end
      total++;
      if (count !== 4'd0 || dn_int !== 1'b0 || ovf !== 1'b1) begin
         bad++;
         $display("FAIL ovf_drain got count=%0d int=%b ovf=%b want 0/0/1", count, dn_int, ovf);
      end
      clr_ovf = 1'b1;
      cyc(1);
      clr_ovf = 1'b0;
      m_ovf   = 1'b0;
      cyc(1);
      total++;
      if (ovf !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear got=%b want=0", ovf);
      end
   endtask

   task automatic test_held_req;
      int lows;
      lows    = 0;
      up_data = 8'h55;
      up_req  = 1'b1;
      cyc(2);
      for (int k = 0; k < 48; k++) begin
         if (up_ack !== 1'b1) lows++;
         @(negedge clk50M);
      end
      total++;
      if (lows != 0) begin
         bad++;
         $display("FAIL held_req_ack got low_cycles=%0d want=0", lows);
      end
      total++;
      if (count !== 4'd1 || dn_data !== 8'h55) begin
         bad++;
         $display("FAIL held_req_count got count=%0d data=%h want 1/55", count, dn_data);
      end
      mq.push_back(8'h55);
      up_req = 1'b0;
      cyc(2);
      total++;
      if (up_ack !== 1'b0) begin
         bad++;
         $display("FAIL held_req_release got=%b want=0", up_ack);
      end
      pop_pulse(1);
   endtask

   task automatic test_full_simul;
      for (int k = 0; k < 8; k++) push_char(8'h60 + 8'(k));
      // Ack rise reaches the pop edge two edges after being driven; req is
      // raised so the push lands on that same edge.
      dn_ack = 1'b1;
      cyc(2);
      up_data = 8'h7E;
      up_req  = 1'b1;
      cyc(2);
      total++;
      if (up_ack !== 1'b1) begin
         bad++;
         $display("FAIL simul_ack got=%b want=1", up_ack);
      end
      up_req = 1'b0;
      dn_ack = 1'b0;
      cyc(4);
      void'(mq.pop_front());
      mq.push_back(8'h7E);
      total++;
      if (count !== 4'd8 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL simul_state got count=%0d ovf=%b want 8/0", count, ovf);
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (dn_data !== mq[0]) begin
            bad++;
            $display("FAIL simul_order[%0d] got=%h want=%h", k, dn_data, mq[0]);
         end
         pop_pulse(1);
      end
   endtask

   task automatic test_held_ack;
      push_char(8'h11);
      push_char(8'h22);
      push_char(8'h33);
      dn_ack = 1'b1;
      cyc(100);
      void'(mq.pop_front());
      total++;
      if (count !== 4'd2 || dn_data !== 8'h22) begin
         bad++;
         $display("FAIL held_ack got count=%0d data=%h want 2/22", count, dn_data);
      end
      dn_ack = 1'b0;
      cyc(5);
      pop_pulse(2);
      pop_pulse(2);
      pop_pulse(2);
      total++;
      if (count !== 4'd0 || dn_int !== 1'b0) begin
         bad++;
         $display("FAIL empty_pop got count=%0d int=%b want 0/0", count, dn_int);
      end
   endtask

   task automatic test_reset_mid;
      for (int k = 0; k < 9; k++) push_char(8'h80 + 8'(k));
      for (int k = 0; k < 4; k++) pop_pulse(1);
      up_data = 8'hA5;
      up_req  = 1'b1;
      cyc(2);
      total++;
      if (up_ack !== 1'b1 || count !== 4'd5 || ovf !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_pre got ack=%b count=%0d ovf=%b want 1/5/1", up_ack, count, ovf);
      end
      rst    = 1'b1;
      up_req = 1'b0;
      cyc(1);
      total++;
      if (up_ack !== 1'b0 || count !== 4'd0 || dn_int !== 1'b0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_clear got ack=%b count=%0d int=%b ovf=%b want 0/0/0/0", up_ack, count, dn_int, ovf);
      end
      rst = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      cyc(1);
      push_char(8'h5A);
      total++;
      if (count !== 4'd1 || dn_data !== 8'h5A || dn_int !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_after got count=%0d data=%h int=%b want 1/5a/1", count, dn_data, dn_int);
      end
      pop_pulse(1);
   endtask

   task automatic test_random;
      int         r;
      logic [7:0] exp_d;
      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            push_char(8'($urandom_range(0, 255)));
         end else if (r <= 8) begin
            pop_pulse($urandom_range(1, 3));
         end else begin
            clr_ovf = 1'b1;
            cyc(1);
            clr_ovf = 1'b0;
            m_ovf   = 1'b0;
            cyc(1);
         end
         exp_d = (mq.size() > 0) ? mq[0] : 8'h00;
         total++;
         if (count !== 4'(mq.size()) || dn_int !== (mq.size() != 0)) begin
            bad++;
            $display("FAIL rand_count[%0d] got count=%0d int=%b want %0d", it, count, dn_int, mq.size());
         end
         total++;
         if (ovf !== m_ovf) begin
            bad++;
            $display("FAIL rand_ovf[%0d] got=%b want=%b", it, ovf, m_ovf);
         end
         total++;
         if (dn_data !== exp_d) begin
            bad++;
            $display("FAIL rand_data[%0d] got=%h want=%h", it, dn_data, exp_d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_held_req();
      test_full_simul();
      test_held_ack();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
